flag_selector: RTL and testbench
================================

// Module: flag_selector
// PURPOSE
//   Drives the flag selector index into the flag lookup (which returns a colour
//   and a flag count) from user buttons and an optional slideshow timer.
//   Sits between the board inputs and the flag lookup in the VGA pixel pipeline.
//   Changes the selector only on frame boundaries, so a flag never tears mid-frame.
// PARAMETERS
//   DEBOUNCE_FRAMES  3    consecutive frame samples a button level must hold to be accepted
//   AUTO_FRAMES      300  frames between slideshow advances (5 s at 60 Hz); minimum 2
//   SYNC_STAGES      2    flip-flop stages in the input synchronisers; minimum 2
// PORTS
//   clk          in   1  pixel clock
//   rst          in   1  asynchronous, active-high reset
//   frame_start  in   1  one-cycle pulse at the start of each frame (from the VGA timing block)
//   btn_next     in   1  raw asynchronous button, active-high
//   btn_prev     in   1  raw asynchronous button, active-high
//   auto_en      in   1  raw asynchronous level; 1 enables the slideshow
//   count        in   8  number of valid flags (constant from the flag lookup)
//   selector     out  8  current flag index, always in [0, count-1], or 0 when count = 0
//   changed      out  1  one-cycle pulse in the cycle after selector takes a new value
// BEHAVIOUR
//   Reset (asynchronous): selector=0, changed=0, both debounced levels=0 (released),
//     debounce counters=0, auto counter=0, pending next/prev requests cleared.
//   Synchronisers: btn_next, btn_prev and auto_en each pass through SYNC_STAGES flops;
//     all later logic uses only the synchronised copies.
//   Debounce (per button, evaluated only on cycles with frame_start=1):
//     - sample == stable level: counter <= 0.
//     - sample != stable level: counter++; when counter reaches DEBOUNCE_FRAMES-1,
//       stable level flips and counter <= 0.
//     - A 0->1 flip of the stable level registers a press flag (next_req or prev_req).
//     - Releases generate no event. Holding a button gives one press, no auto-repeat.
//   Auto timer:
//     - auto_en_sync=0: auto counter held at 0.
//     - Otherwise the counter increments on each frame_start. At AUTO_FRAMES-1 it
//       wraps to 0 and sets auto_req.
//     - Any registered manual press resets the auto counter to 0.
//   Apply step (on frame_start, using requests registered at earlier frame_starts,
//   i.e. one frame of latency), evaluated in this priority order:
//     1. count == 0            -> selector <= 0
//     2. selector >= count     -> selector <= 0 (count shrank)
//     3. next_req && prev_req  -> no change (the two cancel)
//     4. next_req || auto_req  -> selector <= (selector == count-1) ? 0 : selector+1
//     5. prev_req              -> selector <= (selector == 0) ? count-1 : selector-1
//     All requests are cleared in the same cycle. Several requests of the same kind
//     within one frame collapse to a single step.
//   A press flag produced on the same frame_start as an apply step is held for the
//     next apply. It is never lost and never applied twice.
//   changed <= 1 for exactly one cycle when the registered selector value differs
//     from its previous value; otherwise 0.
//   Arithmetic: all comparisons are 8-bit unsigned. The auto counter is
//     $clog2(AUTO_FRAMES) bits wide. Debounce counters are $clog2(DEBOUNCE_FRAMES+1) bits.
//   Mid-frame rst: every output returns to its reset value at once. Operation resumes
//     at the first frame_start after rst deasserts.
// STRUCTURE
//   Shared package flag_pkg: FLAG_IDX_W = 8, and the DEBOUNCE_FRAMES / AUTO_FRAMES
//     defaults, so the flag lookup and this block agree on the index width.
//   One sub-module, button_debounce (synchroniser + frame-sampled debounce + press
//     flag), instantiated twice. Timer, apply logic and the changed pulse live in
//     flag_selector.
// TESTING
//   1. Reset, count=59, hold btn_next for 5 frames -> selector 0->1 exactly once,
//      one changed pulse.
//   2. selector=58, press next -> 0. selector=0, press prev -> 58.
//   3. Button bouncing every 2 frames with DEBOUNCE_FRAMES=3 -> selector unchanged.
//   4. auto_en=1, AUTO_FRAMES=4 -> selector advances every 4 frames. A manual next at
//      frame 2 restarts the 4-frame interval.
//   5. next and prev both press on the same frame -> no change. count forced from 59
//      to 10 with selector=20 -> selector=0 at the next frame_start.
//   6. rst asserted mid-frame with selector=7 -> selector=0 and changed=0 immediately.
//      count=0 -> selector stays 0 under any presses.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the flag selector and the flag lookup, so both sides
// agree on the index width and the default timing parameters.
package flag_pkg;

    localparam int FLAG_IDX_W          = 8;
    localparam int DEBOUNCE_FRAMES_DEF = 3;
    localparam int AUTO_FRAMES_DEF     = 300;
    localparam int SYNC_STAGES_DEF     = 2;

    typedef logic [FLAG_IDX_W-1:0] flag_idx_t;

    typedef enum logic [1:0] {
        APPLY_NONE,
        APPLY_CLEAR,
        APPLY_NEXT,
        APPLY_PREV
    } apply_op_e;

endpackage

// File: rtl/flag_selector_button_debounce.sv
// Synchroniser plus frame-sampled debounce for one raw button. The press output
// is high only during the frame_start cycle that accepts a new pressed level.
module button_debounce #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   stable;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];
    assign accept = frame_start && (sample != stable) && (cnt == CNT_W'(DEBOUNCE_FRAMES - 1));
    assign press  = accept && sample;

    // Any frame sample agreeing with the stable level restarts the run of disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (frame_start) begin
            if (sample == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sample;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flag_selector.sv
// Frame-synchronous flag index selector driven by debounced next/prev buttons
// and an optional slideshow timer; the index only moves on frame_start.
module flag_selector
    import flag_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
    parameter int AUTO_FRAMES     = AUTO_FRAMES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  btn_next,
    input  logic                  btn_prev,
    input  logic                  auto_en,
    input  logic [FLAG_IDX_W-1:0] count,
    output logic [FLAG_IDX_W-1:0] selector,
    output logic                  changed
);

    localparam int AUTO_W = $clog2(AUTO_FRAMES);

    logic [SYNC_STAGES-1:0] auto_sync_q;
    logic                   auto_en_sync;
    logic                   next_press;
    logic                   prev_press;
    logic                   next_req;
    logic                   prev_req;
    logic                   auto_req;
    logic                   auto_wrap;
    logic [AUTO_W-1:0]      auto_cnt;
    logic [AUTO_W-1:0]      auto_cnt_nxt;
    flag_idx_t              sel_nxt;
    flag_idx_t              sel_prev;
    flag_idx_t              last_idx;
    apply_op_e              op;

    button_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_next (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .btn        (btn_next),
        .press      (next_press)
    );

    button_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_prev (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .btn        (btn_prev),
        .press      (prev_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_sync_q <= '0;
        end else begin
            auto_sync_q <= {auto_sync_q[SYNC_STAGES-2:0], auto_en};
        end
    end

    assign auto_en_sync = auto_sync_q[SYNC_STAGES-1];

    // A manual press restarts the slideshow interval so the user gets a full period.
    always_comb begin
        auto_wrap    = 1'b0;
        auto_cnt_nxt = auto_cnt;
        if (next_press || prev_press || !auto_en_sync) begin
            auto_cnt_nxt = '0;
        end else if (auto_cnt == AUTO_W'(AUTO_FRAMES - 1)) begin
            auto_cnt_nxt = '0;
            auto_wrap    = 1'b1;
        end else begin
            auto_cnt_nxt = auto_cnt + 1'b1;
        end
    end

    assign last_idx = count - flag_idx_t'(1);

    always_comb begin
        op = APPLY_NONE;
        if (count == '0 || selector >= count) begin
            op = APPLY_CLEAR;
        end else if (next_req && prev_req) begin
            op = APPLY_NONE;
        end else if (next_req || auto_req) begin
            op = APPLY_NEXT;
        end else if (prev_req) begin
            op = APPLY_PREV;
        end
    end

    always_comb begin
        sel_nxt = selector;
        case (op)
            APPLY_CLEAR: sel_nxt = '0;
            APPLY_NEXT:  sel_nxt = (selector == last_idx) ? '0 : selector + flag_idx_t'(1);
            APPLY_PREV:  sel_nxt = (selector == '0) ? last_idx : selector - flag_idx_t'(1);
            default:     sel_nxt = selector;
        endcase
    end

    // Requests captured at this frame_start are applied at the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selector <= '0;
            sel_prev <= '0;
            changed  <= 1'b0;
            next_req <= 1'b0;
            prev_req <= 1'b0;
            auto_req <= 1'b0;
            auto_cnt <= '0;
        end else begin
            sel_prev <= selector;
            changed  <= (selector != sel_prev);
            if (frame_start) begin
                selector <= sel_nxt;
                next_req <= next_press;
                prev_req <= prev_press;
                auto_req <= auto_wrap;
                auto_cnt <= auto_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_flag_selector.sv
// Directed self-checking bench for flag_selector using 8-cycle frames with the
// frame_start pulse on the fifth cycle of each frame.
module tb_flag_selector;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [7:0] count;
    logic [7:0] selector;
    logic       changed;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    flag_selector #(
        .DEBOUNCE_FRAMES(3),
        .AUTO_FRAMES    (4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .auto_en    (auto_en),
        .count      (count),
        .selector   (selector),
        .changed    (changed)
    );

    task automatic tick();
        @(negedge clk);
        if (changed === 1'b1) pulse_cnt++;
    endtask

    task automatic frame();
        repeat (4) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // Hold the chosen buttons long enough to register, then release until debounced.
    task automatic press(input logic nxt, input logic prv);
        btn_next = nxt;
        btn_prev = prv;
        frames(3);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        frames(3);
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        auto_en = 1'b0; count = 8'd59;
        repeat (3) @(negedge clk);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_selector: got %0d expected 0", selector); end
        n_checks++;
        if (changed !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_changed: got %b expected 0", changed); end
        rst = 1'b0;
        frames(1);
    endtask

    task automatic test_hold_next();
        pulse_cnt = 0;
        btn_next = 1'b1;
        frames(3);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL hold_latency: got %0d expected 0", selector); end
        frames(1);
        n_checks++;
        if (selector !== 8'd1) begin n_fail++; $display("[TB] FAIL hold_step: got %0d expected 1", selector); end
        frames(1);
        btn_next = 1'b0;
        frames(3);
        n_checks++;
        if (selector !== 8'd1) begin n_fail++; $display("[TB] FAIL hold_once: got %0d expected 1", selector); end
        n_checks++;
        if (pulse_cnt !== 1) begin n_fail++; $display("[TB] FAIL hold_pulses: got %0d expected 1", pulse_cnt); end
    endtask

    task automatic test_wrap();
        press(1'b0, 1'b1);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL prev_1_to_0: got %0d expected 0", selector); end
        press(1'b0, 1'b1);
        n_checks++;
        if (selector !== 8'd58) begin n_fail++; $display("[TB] FAIL prev_wrap: got %0d expected 58", selector); end
        press(1'b1, 1'b0);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL next_wrap: got %0d expected 0", selector); end
    endtask

    task automatic test_bounce();
        logic [7:0] pattern;
        pattern = 8'b0011_0011;
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            btn_next = pattern[i];
            frame();
        end
        btn_next = 1'b0;
        frames(2);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL bounce_selector: got %0d expected 0", selector); end
        n_checks++;
        if (pulse_cnt !== 0) begin n_fail++; $display("[TB] FAIL bounce_pulses: got %0d expected 0", pulse_cnt); end
    endtask

    task automatic test_auto();
        int exp_sel [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 4};
        pulse_cnt = 0;
        auto_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            btn_next = (k >= 9 && k <= 11);
            frame();
            n_checks++;
            if (selector !== 8'(exp_sel[k-1])) begin
                n_fail++;
                $display("[TB] FAIL auto_frame_%0d: got %0d expected %0d", k, selector, exp_sel[k-1]);
            end
        end
        btn_next = 1'b0;
        auto_en = 1'b0;
        frames(3);
        n_checks++;
        if (selector !== 8'd4) begin n_fail++; $display("[TB] FAIL auto_disabled: got %0d expected 4", selector); end
        n_checks++;
        if (pulse_cnt !== 4) begin n_fail++; $display("[TB] FAIL auto_pulses: got %0d expected 4", pulse_cnt); end
    endtask

    task automatic test_cancel_and_shrink();
        pulse_cnt = 0;
        press(1'b1, 1'b1);
        n_checks++;
        if (selector !== 8'd4) begin n_fail++; $display("[TB] FAIL cancel_selector: got %0d expected 4", selector); end
        n_checks++;
        if (pulse_cnt !== 0) begin n_fail++; $display("[TB] FAIL cancel_pulses: got %0d expected 0", pulse_cnt); end
        for (int i = 0; i < 16; i++) press(1'b1, 1'b0);
        n_checks++;
        if (selector !== 8'd20) begin n_fail++; $display("[TB] FAIL climb_to_20: got %0d expected 20", selector); end
        count = 8'd10;
        repeat (2) tick();
        n_checks++;
        if (selector !== 8'd20) begin n_fail++; $display("[TB] FAIL shrink_waits_frame: got %0d expected 20", selector); end
        frame();
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL shrink_clear: got %0d expected 0", selector); end
    endtask

    task automatic test_reset_mid_and_empty();
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0);
        btn_next = 1'b1;
        frames(3);
        btn_next = 1'b0;
        repeat (4) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        n_checks++;
        if (selector !== 8'd7) begin n_fail++; $display("[TB] FAIL mid_pre_selector: got %0d expected 7", selector); end
        n_checks++;
        if (changed !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_changed: got %b expected 1", changed); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL mid_rst_selector: got %0d expected 0", selector); end
        n_checks++;
        if (changed !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_changed: got %b expected 0", changed); end
        @(negedge clk);
        rst = 1'b0;
        frames(2);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL post_rst_selector: got %0d expected 0", selector); end

        count = 8'd0;
        pulse_cnt = 0;
        press(1'b1, 1'b0);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL empty_next: got %0d expected 0", selector); end
        press(1'b0, 1'b1);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL empty_prev: got %0d expected 0", selector); end
        press(1'b1, 1'b1);
        n_checks++;
        if (selector !== 8'd0) begin n_fail++; $display("[TB] FAIL empty_both: got %0d expected 0", selector); end
        n_checks++;
        if (pulse_cnt !== 0) begin n_fail++; $display("[TB] FAIL empty_pulses: got %0d expected 0", pulse_cnt); end
    endtask

    initial begin
        test_reset();
        test_hold_next();
        test_wrap();
        test_bounce();
        test_auto();
        test_cancel_and_shrink();
        test_reset_mid_and_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
